// File: rtl/key_sched_ctrl.sv
// Round-key store and sequencer for an external AES-128 key-expansion engine.
// Optional zeroize support (input zeroize, ZERO state) is built when KEY_SCHED_ZEROIZE_EN is defined.
module key_sched_ctrl #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
   input  logic         zeroize,
`endif
   input  logic         key_valid,
   input  logic [127:0] key_data,
   output logic         key_ready,
   output logic         exp_rst,
   output logic         exp_key_valid,
   output logic [127:0] exp_key_in,
   input  logic [127:0] exp_key,
   input  logic [3:0]   exp_addr,
   input  logic         exp_loaded,
   input  logic         rk_req,
   input  logic [3:0]   rk_idx,
   output logic         rk_ack,
   output logic [127:0] rk_data,
   output logic         keys_valid,
   output logic         busy,
   output logic         err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

`ifdef KEY_SCHED_ZEROIZE_EN
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COLLECT, READY, ERROR, ZERO} state_t;
`else
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COLLECT, READY, ERROR} state_t;
`endif

   state_t         state, nxt;
   logic [CW-1:0]  cnt;
   logic [10:0]    mask;
   logic [127:0]   slot [11];
   logic [127:0]   key_q;
   logic [127:0]   rd_sel;
   logic           hs;
   logic           busy_nxt;
`ifdef KEY_SCHED_ZEROIZE_EN
   logic [3:0]     zcnt;
`endif

   assign hs         = key_valid && key_ready;
   assign exp_key_in = key_q;

   always_comb begin
      nxt = state;
      case (state)
         IDLE, READY, ERROR: if (hs) nxt = CLEAR;
         CLEAR:              nxt = LOAD;
         LOAD:               nxt = COLLECT;
         COLLECT: begin
            if (&mask && exp_loaded)
               nxt = READY;
            else if (cnt == CW'(TIMEOUT - 1))
               nxt = ERROR;
         end
`ifdef KEY_SCHED_ZEROIZE_EN
         ZERO:               if (zcnt == 4'd10) nxt = IDLE;
`endif
         default:            nxt = IDLE;
      endcase
`ifdef KEY_SCHED_ZEROIZE_EN
      // zeroize overrides any handshake; a running wipe is not restarted
      if (zeroize && state != ZERO) nxt = ZERO;
`endif
   end

   always_comb begin
      busy_nxt = (nxt == CLEAR) || (nxt == LOAD) || (nxt == COLLECT);
`ifdef KEY_SCHED_ZEROIZE_EN
      if (nxt == ZERO) busy_nxt = 1'b1;
`endif
   end

   // status outputs are registered decodes of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         key_ready     <= 1'b1;
         exp_rst       <= 1'b0;
         exp_key_valid <= 1'b0;
         keys_valid    <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= nxt;
         key_ready     <= (nxt == IDLE) || (nxt == READY) || (nxt == ERROR);
         exp_rst       <= (nxt == CLEAR);
         exp_key_valid <= (nxt == LOAD);
         keys_valid    <= (nxt == READY);
         busy          <= busy_nxt;
         err           <= (nxt == ERROR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q <= '0;
         cnt   <= '0;
         mask  <= '0;
         for (int unsigned i = 0; i < 11; i++) slot[i] <= '0;
      end else begin
         if (hs && nxt == CLEAR) key_q <= key_data;
         if (state == COLLECT) cnt <= cnt + CW'(1);
         else                  cnt <= '0;
         if (state == CLEAR) mask <= '0;
         for (int unsigned i = 0; i < 11; i++) begin
            if (state == COLLECT && exp_addr == 4'(i + 1)) begin
               slot[i] <= exp_key;
               mask[i] <= 1'b1;
            end
`ifdef KEY_SCHED_ZEROIZE_EN
            if (state == ZERO && zcnt == 4'(i)) slot[i] <= '0;
`endif
         end
`ifdef KEY_SCHED_ZEROIZE_EN
         if (state == ZERO) begin
            key_q <= '0;
            mask  <= '0;
         end
`endif
      end
   end

`ifdef KEY_SCHED_ZEROIZE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              zcnt <= '0;
      else if (state == ZERO)  zcnt <= zcnt + 4'd1;
      else                     zcnt <= '0;
   end
`endif

   always_comb begin
      rd_sel = '0;
      for (int unsigned i = 0; i < 11; i++)
         if (rk_idx == 4'(i)) rd_sel = slot[i];
   end

   // slots are untouched until COLLECT, so a read racing a new key returns old data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_ack  <= 1'b0;
         rk_data <= '0;
      end else begin
         rk_ack  <= rk_req && keys_valid;
         rk_data <= (rk_req && keys_valid) ? rd_sel : '0;
      end
   end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl: directed stimulus, queued read expectations.
module tb_key_sched_ctrl;

   localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2   = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [127:0] JUNK = 128'hbadbadbadbadbadbadbadbadbadbad00;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid, key_ready;
   logic [127:0] key_data;
   logic         exp_rst, exp_key_valid;
   logic [127:0] exp_key_in, exp_key;
   logic [3:0]   exp_addr;
   logic         exp_loaded;
   logic         rk_req, rk_ack;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         keys_valid, busy, err;
`ifdef KEY_SCHED_ZEROIZE_EN
   logic         zeroize;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [127:0] exp_q [$];
   logic [127:0] rk_tab [11];

   always #5 clk = ~clk;

   key_sched_ctrl #(.TIMEOUT(32)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
      .exp_rst(exp_rst), .exp_key_valid(exp_key_valid), .exp_key_in(exp_key_in),
      .exp_key(exp_key), .exp_addr(exp_addr), .exp_loaded(exp_loaded),
      .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack), .rk_data(rk_data),
      .keys_valid(keys_valid), .busy(busy), .err(err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   // monitor: every ack must match the oldest queued expectation
   always @(negedge clk) begin
      if (rk_ack) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rk_ack_unexpected: got ack data %h, want no ack", rk_data);
         end else begin
            chk("rk_data", rk_data, exp_q.pop_front());
         end
      end else begin
         chk("rk_data_noack", rk_data, '0);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_key_ready"}, key_ready, 1);
      chk({tag, "_keys_valid"}, keys_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_rk_ack"}, rk_ack, 0);
      chk({tag, "_rk_data"}, rk_data, '0);
      chk({tag, "_exp_rst"}, exp_rst, 0);
      chk({tag, "_exp_key_valid"}, exp_key_valid, 0);
      chk({tag, "_exp_key_in"}, exp_key_in, '0);
   endtask

   function automatic logic [127:0] rk_of(input int i, input bit inv);
      return inv ? ~rk_tab[i] : rk_tab[i];
   endfunction

   task automatic send_key(input logic [127:0] k, input bit want_ack);
      exp_addr   = 4'd0;
      exp_loaded = 1'b0;
      exp_key    = '0;
      chk("key_ready_pre", key_ready, 1);
      key_data  = k;
      key_valid = 1'b1;
      tick;
      key_valid = 1'b0;
      rk_req    = 1'b0;
      chk("clear_ack", rk_ack, want_ack);
      chk("clear_keys_valid", keys_valid, 0);
      chk("clear_key_ready", key_ready, 0);
      chk("clear_exp_rst", exp_rst, 1);
      chk("clear_busy", busy, 1);
      tick;
      chk("load_exp_rst", exp_rst, 0);
      chk("load_exp_key_valid", exp_key_valid, 1);
      chk("load_exp_key_in", exp_key_in, k);
      tick;
      chk("collect_exp_key_valid", exp_key_valid, 0);
      chk("collect_busy", busy, 1);
   endtask

   task automatic engine(input int a, input logic [127:0] d, input bit ld);
      exp_addr   = 4'(a);
      exp_key    = d;
      exp_loaded = ld;
      tick;
   endtask

   // junk on slot 3 first (later overwritten), junk on invalid addresses after
   task automatic expand(input bit inv);
      engine(3, JUNK, 0);
      for (int a = 1; a <= 11; a++) engine(a, rk_of(a - 1, inv), 0);
      engine(12, JUNK, 0);
      engine(0, JUNK, 0);
      engine(15, JUNK, 0);
      chk("kv_before_loaded", keys_valid, 0);
      engine(0, '0, 1);
      chk("kv_ready", keys_valid, 1);
      chk("ready_busy", busy, 0);
      chk("ready_err", err, 0);
      chk("ready_key_ready", key_ready, 1);
   endtask

   task automatic sweep(input bit inv);
      for (int i = 0; i < 13; i++) begin
         rk_req = 1'b1;
         rk_idx = 4'(i);
         if (i < 11) exp_q.push_back(rk_of(i, inv));
         else        exp_q.push_back('0);
         tick;
         chk("sweep_ack", rk_ack, 1);
      end
      rk_req = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      int cyc;
      rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      rst_n = 1'b0; key_valid = 1'b0; key_data = '0;
      exp_key = '0; exp_addr = 4'd0; exp_loaded = 1'b0;
      rk_req = 1'b0; rk_idx = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      #12;
      chk_rst("por");
      @(negedge clk) rst_n = 1'b1;
      tick;

      // read request without stored keys gets no ack
      rk_req = 1'b1;
      tick;
      tick;
      rk_req = 1'b0;
      tick;

      send_key(K1, 0);
      expand(0);
      rk_req = 1'b1;
      rk_idx = 4'd10;
      exp_q.push_back(128'h13111d7fe3944a17f307a78b4d2b30c5);
      tick;
      rk_req = 1'b0;
      chk("rk_ack_idx10", rk_ack, 1);
      tick;
      chk("rk_ack_single", rk_ack, 0);
      sweep(0);

      // read and new key in the same cycle, then engine stalls after slot 5
      rk_req = 1'b1;
      rk_idx = 4'd3;
      exp_q.push_back(rk_tab[3]);
      send_key(K2, 1);
      cyc = 0;
      while (!err && cyc < 100) begin
         exp_addr = (cyc < 5) ? 4'(cyc + 1) : 4'd0;
         exp_key  = (cyc < 5) ? ~rk_tab[cyc] : JUNK;
         tick;
         cyc++;
      end
      chk("timeout_cycles", cyc, 32);
      chk("timeout_err", err, 1);
      chk("timeout_keys_valid", keys_valid, 0);
      chk("timeout_busy", busy, 0);
      chk("timeout_key_ready", key_ready, 1);

      send_key(K1, 0);
      chk("restart_err", err, 0);
      expand(0);
      sweep(0);

      // reset lands on a pending read: no ack may follow
      rk_req = 1'b1;
      rk_idx = 4'd2;
      #2 rst_n = 1'b0;
      #1 chk_rst("rst_ready");
      rk_req = 1'b0;
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick;

      // reset in the middle of collection
      send_key(K2, 0);
      for (int a = 1; a <= 4; a++) engine(a, ~rk_tab[a - 1], 0);
      #2 rst_n = 1'b0;
      #1 chk_rst("rst_collect");
      exp_addr = 4'd0;
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick;
      send_key(K2, 0);
      expand(1);
      sweep(1);

`ifdef KEY_SCHED_ZEROIZE_EN
      zeroize   = 1'b1;
      key_valid = 1'b1;
      key_data  = K1;
      tick;
      zeroize   = 1'b0;
      key_valid = 1'b0;
      chk("zero_key_ready", key_ready, 0);
      chk("zero_keys_valid", keys_valid, 0);
      chk("zero_exp_rst", exp_rst, 0);
      cyc = 0;
      while (busy && cyc < 50) begin
         cyc++;
         tick;
      end
      chk("zero_busy_cycles", cyc, 11);
      chk("zero_idle_key_ready", key_ready, 1);
      chk("zero_idle_keys_valid", keys_valid, 0);
`endif

      tick;
      tick;
      chk("sb_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
